// File: rtl/knight_rider_pkg.sv
// Shared types and defaults for the knight-rider sequencer and its prescaler.
package knight_rider_pkg;

  localparam int N_LEDS_DEF     = 8;
  localparam int PRESCALE_DEF   = 1024;
  localparam int STEP_TICKS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int pos_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knight_rider_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
module tick_gen
  import knight_rider_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = pos_width(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // hold_i keeps the count parked at zero until the reset release has synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (hold_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_LAST);
      cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/knight_rider_ctrl.sv
// Sweep sequencer: one-hot select bouncing or wrapping across a bank of fade engines.
//   state    | meaning
//   IDLE     | sel all zero, waiting for an en rising edge
//   RUN_UP   | position index increasing each step
//   RUN_DOWN | position index decreasing each step (bounce mode only)
module knight_rider_ctrl
  import knight_rider_pkg::*;
#(
  parameter int N_LEDS     = N_LEDS_DEF,
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int STEP_TICKS = STEP_TICKS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         oneshot,
  input  logic                         wrap,
  output logic                         tick,
  output logic [N_LEDS-1:0]            sel,
  output logic [pos_width(N_LEDS)-1:0] pos,
  output logic                         dir,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = pos_width(N_LEDS);
  localparam int SW = pos_width(STEP_TICKS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_TURN  = PW'(N_LEDS - 2);

  logic [1:0]        rst_sync_q;
  logic              hold;
  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              dir_q, dir_d;
  logic [SW-1:0]     step_q, step_d;
  logic              oneshot_q, oneshot_d;
  logic              wrap_q, wrap_d;
  logic              en_q;
  logic [N_LEDS-1:0] sel_q, sel_d;
  logic              done_q, done_d;
  logic              adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign hold = ~rst_sync_q[1];

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (hold),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_d    = step_q;
    oneshot_d = oneshot_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    adv       = 1'b0;
    sel_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (en && !en_q) begin
          state_d   = RUN_UP;
          pos_d     = '0;
          dir_d     = 1'b0;
          step_d    = '0;
          oneshot_d = oneshot;
          wrap_d    = wrap;
        end
      end
      RUN_UP, RUN_DOWN: begin
        // Stop takes priority over a coincident step expiry.
        if (!en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            adv    = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (state_q == RUN_UP) begin
        if (pos_q != POS_LAST) begin
          pos_d = pos_q + 1'b1;
        end else if (!wrap_q) begin
          pos_d   = POS_TURN;
          state_d = RUN_DOWN;
          dir_d   = 1'b1;
        end else if (!oneshot_q) begin
          pos_d = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        if (pos_q != '0) begin
          pos_d = pos_q - 1'b1;
        end else if (!oneshot_q) begin
          pos_d   = PW'(1);
          state_d = RUN_UP;
          dir_d   = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end

    if (state_d == RUN_UP || state_d == RUN_DOWN) sel_d = N_LEDS'(1) << pos_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= '0;
      oneshot_q <= 1'b0;
      wrap_q    <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      done_q    <= 1'b0;
    end else if (hold) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= '0;
      oneshot_q <= 1'b0;
      wrap_q    <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      oneshot_q <= oneshot_d;
      wrap_q    <= wrap_d;
      en_q      <= en;
      sel_q     <= sel_d;
      done_q    <= done_d;
    end
  end

  assign sel  = sel_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign done = done_q;
  assign busy = (state_q == RUN_UP) || (state_q == RUN_DOWN);

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Directed bench for knight_rider_ctrl with N_LEDS=4, PRESCALE=4, STEP_TICKS=2.
module tb_knight_rider_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       oneshot = 1'b0;
  logic       wrap = 1'b0;
  logic       tick;
  logic [3:0] sel;
  logic [1:0] pos;
  logic       dir, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knight_rider_ctrl #(.N_LEDS(4), .PRESCALE(4), .STEP_TICKS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .oneshot (oneshot),
    .wrap    (wrap),
    .tick    (tick),
    .sel     (sel),
    .pos     (pos),
    .dir     (dir),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_change(output int n);
    logic [3:0] prev;
    prev = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel === prev && n < 40);
    if (sel === prev) begin
      checks++;
      errors++;
      $error("FAIL sel_change_timeout observed=%0h expected=change", sel);
    end
  endtask

  // After a release placed 2ns past a negedge, the first tick is seen on the 6th negedge.
  task automatic tick_pattern(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk(tag, tick, (i >= 6 && (i - 6) % 4 == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] es [8];
    logic [1:0] ep [8];
    logic       ed [8];
    int n;
    int bad;

    #11;
    chk("rst_tick", tick, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1 rst_n = 1'b1;
    tick_pattern("p1_tick", 20);
    chk("p1_sel", sel, 0);
    chk("p1_busy", busy, 0);

    // continuous bounce; mode inputs flipped mid-sweep must be ignored
    en = 1'b1;
    @(negedge clk);
    chk("p2_start_sel", sel, 4'b0001);
    chk("p2_start_busy", busy, 1);
    chk("p2_start_pos", pos, 0);
    chk("p2_start_dir", dir, 0);
    wrap = 1'b1;
    oneshot = 1'b1;
    es = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0000};
    ep = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      wait_change(n);
      chk("p2_sel", sel, es[k]);
      chk("p2_pos", pos, ep[k]);
      chk("p2_dir", dir, ed[k]);
      chk("p2_dwell", n, (k == 0) ? 6 : 8);
    end

    en = 1'b0;
    wrap = 1'b0;
    @(negedge clk);
    chk("p2_stop_sel", sel, 0);
    chk("p2_stop_busy", busy, 0);
    chk("p2_stop_done", done, 0);

    // oneshot bounce, en held high afterwards
    oneshot = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("p3_start_sel", sel, 4'b0001);
    es = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      wait_change(n);
      chk("p3_sel", sel, es[k]);
      if (k > 0) chk("p3_dwell", n, 8);
    end
    wait_change(n);
    chk("p3_end_sel", sel, 0);
    chk("p3_end_done", done, 1);
    chk("p3_end_busy", busy, 0);
    chk("p3_end_dwell", n, 8);
    @(negedge clk);
    chk("p3_done_pulse", done, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || sel != 4'b0000) bad++;
    end
    chk("p3_no_restart", bad, 0);

    // continuous wrap
    en = 1'b0;
    @(negedge clk);
    oneshot = 1'b0;
    wrap = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("p4_start_sel", sel, 4'b0001);
    es = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    ep = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int k = 0; k < 4; k++) begin
      wait_change(n);
      chk("p4_sel", sel, es[k]);
      chk("p4_pos", pos, ep[k]);
      chk("p4_dir", dir, 0);
      if (k > 0) chk("p4_dwell", n, 8);
    end

    // drop en exactly on the step expiry out of pos 2
    wait_change(n);
    chk("p5_sel1", sel, 4'b0010);
    chk("p5_dwell1", n, 8);
    wait_change(n);
    chk("p5_sel2", sel, 4'b0100);
    chk("p5_dwell2", n, 8);
    repeat (7) @(negedge clk);
    chk("p5_pre_tick", tick, 1);
    chk("p5_pre_sel", sel, 4'b0100);
    en = 1'b0;
    @(negedge clk);
    chk("p5_sel", sel, 0);
    chk("p5_busy", busy, 0);
    chk("p5_done", done, 0);
    chk("p5_pos_kept", pos, 2);
    chk("p5_tick_low", tick, 0);
    repeat (3) @(negedge clk);
    chk("p5_tick_runs", tick, 1);

    // async reset mid-sweep
    wrap = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("p6_start_busy", busy, 1);
    wait_change(n);
    chk("p6_sel", sel, 4'b0010);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("p6_rst_tick", tick, 0);
    chk("p6_rst_sel", sel, 0);
    chk("p6_rst_pos", pos, 0);
    chk("p6_rst_dir", dir, 0);
    chk("p6_rst_busy", busy, 0);
    chk("p6_rst_done", done, 0);
    #1 rst_n = 1'b1;
    tick_pattern("p6_tick", 10);
    chk("p6_post_sel", sel, 0);
    chk("p6_post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
